stage_memory: RTL

- Pipeline stage directly downstream of the execute stage; consumes the EX/MEM register outputs and produces the MEM/WB register.
- Runs loads and stores on a request/grant/response data-memory port, aligns byte/half lanes and sign-extends loads.
- Stalls upstream while an access is outstanding.
- Its registered outputs (mem_rd, mem_alu_result, mem_regfile_wr_enable) are the forwarding sources for execute.

---
 rtl/core_mem_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/stage_memory.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_pkg.sv
// Shared encodings for the memory stage: result-select codes, load/store size
// codes and the data-bus FSM state type.
package core_mem_pkg;

   localparam logic [1:0] ALU_RESULT = 2'b00;
   localparam logic [1:0] MEM_TO_REG = 2'b01;
   localparam logic [1:0] PC_PLUS    = 2'b10;
   localparam logic [1:0] LUI_AUIPC  = 2'b11;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10
   } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables and replicated store data,
// plus right-aligned, sign/zero-extended load data.
module mem_lane_align
   import core_mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
);

   logic [31:0] shifted_s;

   // Store side: enables follow the size, data is replicated into every lane.
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = store_data_i;
      case (funct3_i)
         F3_B: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{store_data_i[7:0]}};
         end
         F3_H: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{store_data_i[15:0]}};
         end
         F3_W: begin
            be_o    = 4'b1111;
            wdata_o = store_data_i;
         end
         default: begin
            be_o    = 4'b0000;
            wdata_o = store_data_i;
         end
      endcase
   end

   assign shifted_s = rdata_i >> {addr_lo_i, 3'b000};

   // Load side: extract the addressed lane and extend it to 32 bits.
   always_comb begin
      load_data_o = 32'h0000_0000;
      case (funct3_i)
         F3_B:    load_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
         F3_BU:   load_data_o = {24'h00_0000, shifted_s[7:0]};
         F3_H:    load_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
         F3_HU:   load_data_o = {16'h0000, shifted_s[15:0]};
         F3_W:    load_data_o = shifted_s;
         default: load_data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: drives the request/grant/response data port, stalls
// upstream while busy and holds the MEM/WB register. Optional: MISALIGN_TRAP_EN.
module stage_memory
   import core_mem_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 255,
   parameter int unsigned TIMEOUT_W   = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  execute_rd,
   input  logic        execute_regfile_wr_enable,
   input  logic [1:0]  execute_result_src,
   input  logic        execute_datamem_wr_enable,
   input  logic [2:0]  execute_funct3,
   input  logic [31:0] execute_alu_result,
   input  logic [31:0] execute_wr_datamem_data,
   input  logic [31:0] execute_instr_addr_plus,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [4:0]  mem_rd,
   output logic        mem_regfile_wr_enable,
   output logic [1:0]  mem_result_src,
   output logic [31:0] mem_alu_result,
   output logic [31:0] mem_read_data,
   output logic [31:0] mem_instr_addr_plus,
   output logic        mem_bus_error
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        mem_misaligned
`endif
);

   localparam logic [TIMEOUT_W:0] TO_LIMIT = (TIMEOUT_W+1)'(BUS_TIMEOUT);

   mem_state_e           state_q, state_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   logic        is_load_s, is_store_s, mem_op_s, bus_op_s, misaligned_s;
   logic        req_s, done_s, abort_s, timeout_hit_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s, load_data_s;

   logic [4:0]  mem_rd_q;
   logic        mem_wr_en_q;
   logic [1:0]  mem_src_q;
   logic [31:0] mem_alu_q, mem_rdata_q, mem_pc_q;
   logic        mem_err_q;
   logic        mem_misaligned_q;

   assign is_load_s  = (execute_result_src == MEM_TO_REG);
   assign is_store_s = execute_datamem_wr_enable;
   assign mem_op_s   = is_load_s | is_store_s;

`ifdef MISALIGN_TRAP_EN
   assign misaligned_s = mem_op_s &
      ((((execute_funct3 == F3_H) | (is_load_s & (execute_funct3 == F3_HU))) & execute_alu_result[0]) |
       ((execute_funct3 == F3_W) & (execute_alu_result[1:0] != 2'b00)));
`else
   assign misaligned_s = 1'b0;
`endif

   // A trapped misaligned access never touches the bus.
   assign bus_op_s = mem_op_s & ~misaligned_s;

   assign timeout_hit_s = (BUS_TIMEOUT != 32'd0) &&
                          (({1'b0, cnt_q} + (TIMEOUT_W+1)'(1)) >= TO_LIMIT);

   mem_lane_align u_align (
      .funct3_i     (execute_funct3),
      .addr_lo_i    (execute_alu_result[1:0]),
      .store_data_i (execute_wr_datamem_data),
      .rdata_i      (dmem_rdata),
      .be_o         (be_s),
      .wdata_o      (wdata_s),
      .load_data_o  (load_data_s)
   );

   // Bus FSM next state, watchdog counter and completion decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_s   = 1'b0;
      done_s  = 1'b0;
      abort_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus_op_s) begin
               req_s = 1'b1;
               cnt_d = '0;
               if (dmem_gnt) begin
                  if (is_load_s) begin
                     state_d = ST_RESP;
                  end else begin
                     done_s = 1'b1;
                  end
               end else begin
                  state_d = ST_REQ;
               end
            end else begin
               done_s = 1'b1;
            end
         end
         ST_REQ: begin
            req_s = 1'b1;
            if (dmem_gnt) begin
               cnt_d = '0;
               if (is_load_s) begin
                  state_d = ST_RESP;
               end else begin
                  done_s  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (timeout_hit_s) begin
               abort_s = 1'b1;
               done_s  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         ST_RESP: begin
            if (dmem_rvalid) begin
               done_s  = 1'b1;
               state_d = ST_IDLE;
            end else if (timeout_hit_s) begin
               abort_s = 1'b1;
               done_s  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM state and watchdog registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_stall  = mem_op_s & ~done_s;
   assign dmem_req   = req_s & ~rst;
   assign dmem_we    = dmem_req & is_store_s;
   assign dmem_be    = dmem_req ? be_s : 4'b0000;
   assign dmem_addr  = {execute_alu_result[31:2], 2'b00};
   assign dmem_wdata = wdata_s;

   // MEM/WB register: capture on completion, otherwise insert a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_rd_q         <= 5'd0;
         mem_wr_en_q      <= 1'b0;
         mem_src_q        <= 2'b00;
         mem_alu_q        <= 32'h0000_0000;
         mem_rdata_q      <= 32'h0000_0000;
         mem_pc_q         <= 32'h0000_0000;
         mem_err_q        <= 1'b0;
         mem_misaligned_q <= 1'b0;
      end else if (done_s) begin
         mem_rd_q         <= execute_rd;
         mem_wr_en_q      <= execute_regfile_wr_enable & ~abort_s & ~misaligned_s;
         mem_src_q        <= execute_result_src;
         mem_alu_q        <= execute_alu_result;
         mem_rdata_q      <= abort_s ? 32'h0000_0000 : load_data_s;
         mem_pc_q         <= execute_instr_addr_plus;
         mem_err_q        <= abort_s;
         mem_misaligned_q <= misaligned_s;
      end else begin
         mem_wr_en_q      <= 1'b0;
         mem_err_q        <= 1'b0;
         mem_misaligned_q <= 1'b0;
      end
   end

   assign mem_rd                = mem_rd_q;
   assign mem_regfile_wr_enable = mem_wr_en_q;
   assign mem_result_src        = mem_src_q;
   assign mem_alu_result        = mem_alu_q;
   assign mem_read_data         = mem_rdata_q;
   assign mem_instr_addr_plus   = mem_pc_q;
   assign mem_bus_error         = mem_err_q;

`ifdef MISALIGN_TRAP_EN
   assign mem_misaligned = mem_misaligned_q;
`else
   logic unused_misaligned_s;
   assign unused_misaligned_s = mem_misaligned_q;
`endif

endmodule
